aes_inv_cipher_128: RTL

AES_INV_CIPHER_128 -- requirements
Module: aes_inv_cipher_128

---
 rtl/aes_inv_cipher_128.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_128.sv
// AES-128 inverse cipher, one round per clock.
// The forward key schedule runs first (EXPAND) to reach rk10. The decrypt
// rounds then walk the schedule backwards, one key per round, so only one
// round key is ever stored.
// Optional key cache: define AES_INV_KEY_CACHE_EN to keep the last key and
// its rk10. A start with the same key then skips EXPAND (latency 10, not 20).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for Valid; Busy=0
// EXPAND  | forward key schedule rk1..rk10; rnd_q = index being produced
// DECRYPT | inverse rounds 9..0; rnd_q = index of the round key held in rk_q
`timescale 1ns/1ps
module aes_inv_cipher_128 (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic         Valid,
   input  logic [127:0] Key,
   input  logic [127:0] Cypher_txt,
   output logic [127:0] Plain_txt,
   output logic         Busy,
   output logic         Done
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DECRYPT = 2'd2} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = a;
      res = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] x;
      x = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(x);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // InvShiftRows + InvSubBytes + AddRoundKey (+ InvMixColumns unless last)
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [127:0] b;
      logic [127:0] m;
      b = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * (r + 4 * ((c + 4 - r) % 4)) -: 8]);
         end
      end
      b = b ^ rk;
      m = b;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            m[127 - 32 * c -: 32] = inv_mix_col(b[127 - 32 * c -: 32]);
         end
      end
      return m;
   endfunction

   state_t         state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [127:0]   rk_q, rk_d;
   logic [127:0]   st_q, st_d;
   logic [127:0]   plain_q, plain_d;
   logic           done_q, done_d;
   logic           start;
   logic [31:0]    sw_in;
   logic [31:0]    sw_out;
   logic [127:0]   rk_fwd;
   logic [127:0]   rk_rev;

`ifdef AES_INV_KEY_CACHE_EN
   logic [127:0]   cache_key_q, cache_key_d;
   logic [127:0]   cache_rk_q, cache_rk_d;
   logic           cache_vld_q, cache_vld_d;
   logic           cache_hit;
`endif

   // next-state, round datapath and shared SubWord for both key-schedule directions
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      rk_d    = rk_q;
      st_d    = st_q;
      plain_d = plain_q;
      done_d  = 1'b0;
      start   = Valid && (state_q == IDLE) && !done_q;
      // backwards, the word fed to SubWord is the recovered w3 = w3 ^ w2
      sw_in   = (state_q == EXPAND) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
      sw_out  = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon(rnd_q), 24'h0};
      rk_fwd[127:96] = rk_q[127:96] ^ sw_out;
      rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
      rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
      rk_fwd[31:0]   = rk_q[31:0] ^ rk_fwd[63:32];
      rk_rev[127:96] = rk_q[127:96] ^ sw_out;
      rk_rev[95:64]  = rk_q[95:64] ^ rk_q[127:96];
      rk_rev[63:32]  = rk_q[63:32] ^ rk_q[95:64];
      rk_rev[31:0]   = rk_q[31:0] ^ rk_q[63:32];
`ifdef AES_INV_KEY_CACHE_EN
      cache_key_d = cache_key_q;
      cache_rk_d  = cache_rk_q;
      cache_vld_d = cache_vld_q;
      cache_hit   = cache_vld_q && (Key == cache_key_q);
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef AES_INV_KEY_CACHE_EN
               if (cache_hit) begin
                  rk_d    = cache_rk_q;
                  st_d    = Cypher_txt ^ cache_rk_q;
                  rnd_d   = 4'd10;
                  state_d = DECRYPT;
               end else begin
                  // key is recorded now; the flag stays low until its rk10 exists
                  cache_key_d = Key;
                  cache_vld_d = 1'b0;
                  rk_d        = Key;
                  st_d        = Cypher_txt;
                  rnd_d       = 4'd1;
                  state_d     = EXPAND;
               end
`else
               rk_d    = Key;
               st_d    = Cypher_txt;
               rnd_d   = 4'd1;
               state_d = EXPAND;
`endif
            end
         end
         EXPAND: begin
            rk_d = rk_fwd;
            if (rnd_q == 4'd10) begin
               st_d    = st_q ^ rk_fwd;
               state_d = DECRYPT;
`ifdef AES_INV_KEY_CACHE_EN
               cache_rk_d  = rk_fwd;
               cache_vld_d = 1'b1;
`endif
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         DECRYPT: begin
            rk_d  = rk_rev;
            st_d  = inv_round(st_q, rk_rev, rnd_q == 4'd1);
            rnd_d = rnd_q - 4'd1;
            if (rnd_q == 4'd1) begin
               plain_d = st_d;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, key, datapath and output registers
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rnd_q   <= 4'd0;
         rk_q    <= '0;
         st_q    <= '0;
         plain_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         rk_q    <= rk_d;
         st_q    <= st_d;
         plain_q <= plain_d;
         done_q  <= done_d;
      end
   end

`ifdef AES_INV_KEY_CACHE_EN
   // cached key and its rk10
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cache_key_q <= '0;
         cache_rk_q  <= '0;
         cache_vld_q <= 1'b0;
      end else begin
         cache_key_q <= cache_key_d;
         cache_rk_q  <= cache_rk_d;
         cache_vld_q <= cache_vld_d;
      end
   end
`endif

   assign Plain_txt = plain_q;
   assign Done      = done_q;
   assign Busy      = (state_q != IDLE);

endmodule
